// File: rtl/gbuff_tile_reader.sv
// Global-buffer tile reader: walks a rows x cols tile in row-major order and
// streams the words through a 2-entry FIFO with valid/ready handshaking.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module gbuff_tile_reader #(
   parameter int unsigned DIM_WIDTH = 8
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   start_i,
   input  logic [`ADDR_WIDTH-1:0] base_addr_i,
   input  logic [DIM_WIDTH-1:0]   rows_i,
   input  logic [DIM_WIDTH-1:0]   cols_i,
   input  logic [`ADDR_WIDTH-1:0] stride_i,
   output logic                   busy_o,
   output logic                   done_o,
   output logic                   gb_wr_en_o,
   output logic [`ADDR_WIDTH-1:0] gb_addr_o,
   input  logic [`WORD_WIDTH-1:0] gb_data_i,
   output logic [`WORD_WIDTH-1:0] data_o,
   output logic                   valid_o,
   input  logic                   ready_i,
   output logic                   last_o
);

   localparam int unsigned AW = `ADDR_WIDTH;
   localparam int unsigned WW = `WORD_WIDTH;

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_e;

   state_e               state_q, state_d;

   logic [DIM_WIDTH-1:0] rows_q, cols_q, row_q, col_q;
   logic [AW-1:0]        stride_q, row_ptr_q, addr_q;
   logic                 inflight_q, inflight_last_q;
   logic [WW-1:0]        fifo_data_q [2];
   logic                 fifo_last_q [2];
   logic                 rd_ptr_q, wr_ptr_q;
   logic [1:0]           fifo_cnt_q;
   logic                 done_q, done_d;

   logic                 accept_c, zero_cmd_c, issue_c, final_c, pop_c, push_c;
   logic [2:0]           occ_c;
   logic [AW-1:0]        cur_addr_c;

   assign zero_cmd_c = (rows_i == '0) || (cols_i == '0);
   assign final_c    = (row_q == rows_q - DIM_WIDTH'(1)) && (col_q == cols_q - DIM_WIDTH'(1));
   assign cur_addr_c = row_ptr_q + AW'(col_q);
   assign pop_c      = valid_o & ready_i;
   assign push_c     = inflight_q;
   assign occ_c      = 3'(fifo_cnt_q) + 3'(inflight_q);

   // State register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_i && !zero_cmd_c) state_d = RUN;
         RUN:     if (issue_c && final_c)     state_d = DRAIN;
         DRAIN:   if (pop_c && last_o)        state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Control outputs; a read is issued only if the FIFO can absorb it next cycle
   always_comb begin
      accept_c = 1'b0;
      issue_c  = 1'b0;
      done_d   = 1'b0;
      case (state_q)
         IDLE: begin
            accept_c = start_i && !zero_cmd_c;
            done_d   = start_i && zero_cmd_c;
         end
         RUN:     issue_c = (occ_c < (3'd2 + 3'(pop_c)));
         DRAIN:   done_d  = pop_c && last_o;
         default: ;
      endcase
   end

   // Command latch and incremental row-major address walk
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rows_q    <= '0;
         cols_q    <= '0;
         stride_q  <= '0;
         row_ptr_q <= '0;
         row_q     <= '0;
         col_q     <= '0;
         addr_q    <= '0;
      end else if (accept_c) begin
         rows_q    <= rows_i;
         cols_q    <= cols_i;
         stride_q  <= stride_i;
         row_ptr_q <= base_addr_i;
         row_q     <= '0;
         col_q     <= '0;
      end else if (issue_c) begin
         addr_q <= cur_addr_c;
         if (col_q == cols_q - DIM_WIDTH'(1)) begin
            col_q     <= '0;
            row_q     <= row_q + DIM_WIDTH'(1);
            row_ptr_q <= row_ptr_q + stride_q;
         end else begin
            col_q <= col_q + DIM_WIDTH'(1);
         end
      end
   end

   // Read pipeline tracking and output FIFO
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
         fifo_data_q[0]  <= '0;
         fifo_data_q[1]  <= '0;
         fifo_last_q[0]  <= 1'b0;
         fifo_last_q[1]  <= 1'b0;
         rd_ptr_q        <= 1'b0;
         wr_ptr_q        <= 1'b0;
         fifo_cnt_q      <= '0;
         done_q          <= 1'b0;
      end else begin
         inflight_q      <= issue_c;
         inflight_last_q <= issue_c && final_c;
         done_q          <= done_d;
         if (push_c) begin
            fifo_data_q[wr_ptr_q] <= gb_data_i;
            fifo_last_q[wr_ptr_q] <= inflight_last_q;
            wr_ptr_q              <= ~wr_ptr_q;
         end
         if (pop_c) rd_ptr_q <= ~rd_ptr_q;
         case ({push_c, pop_c})
            2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
            2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
            default: ;
         endcase
      end
   end

   assign busy_o     = (state_q != IDLE);
   assign done_o     = done_q;
   assign gb_wr_en_o = 1'b0;
   assign gb_addr_o  = issue_c ? cur_addr_c : addr_q;
   assign valid_o    = (fifo_cnt_q != 2'd0);
   assign data_o     = fifo_data_q[rd_ptr_q];
   assign last_o     = valid_o && fifo_last_q[rd_ptr_q];

endmodule

// File: tb/tb_gbuff_tile_reader.sv
// Directed bench for gbuff_tile_reader with a one-cycle-latency buffer model.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module tb_gbuff_tile_reader;

   localparam int unsigned AW = `ADDR_WIDTH;
   localparam int unsigned WW = `WORD_WIDTH;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [7:0]    rows = '0;
   logic [7:0]    cols = '0;
   logic [AW-1:0] stride = '0;
   logic          busy_o, done_o, gb_wr_en_o, valid_o, last_o;
   logic [AW-1:0] gb_addr_o;
   logic [WW-1:0] gb_data = '0;
   logic [WW-1:0] data_o;
   logic          ready = 1'b0;

   int            n_vec = 0;
   int            n_err = 0;
   logic [AW-1:0] exp_addr [8];

   gbuff_tile_reader #(.DIM_WIDTH(8)) dut (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .base_addr_i(base_addr),
      .rows_i(rows), .cols_i(cols), .stride_i(stride), .busy_o(busy_o),
      .done_o(done_o), .gb_wr_en_o(gb_wr_en_o), .gb_addr_o(gb_addr_o),
      .gb_data_i(gb_data), .data_o(data_o), .valid_o(valid_o),
      .ready_i(ready), .last_o(last_o)
   );

   always #5 clk = ~clk;

   function automatic logic [WW-1:0] word(input logic [AW-1:0] a);
      return WW'({~a, a});
   endfunction

   // Buffer model: data registered one cycle after the address, never reset
   always @(posedge clk) gb_data <= word(gb_addr_o);

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_busy"}, 64'(busy_o), 64'd0);
      chk({tag, "_done"}, 64'(done_o), 64'd0);
      chk({tag, "_valid"}, 64'(valid_o), 64'd0);
      chk({tag, "_last"}, 64'(last_o), 64'd0);
      chk({tag, "_wren"}, 64'(gb_wr_en_o), 64'd0);
      chk({tag, "_addr"}, 64'(gb_addr_o), 64'd0);
      chk({tag, "_data"}, 64'(data_o), 64'd0);
   endtask

   // Full-rate command: addresses in cycles 1..n, data in 3..n+2, done at n+3
   task automatic run_full(input logic [AW-1:0] b, input logic [7:0] r, input logic [7:0] c,
                           input logic [AW-1:0] s, input int n, input bit glitch);
      @(negedge clk);
      start = 1'b1; base_addr = b; rows = r; cols = c; stride = s; ready = 1'b1;
      #1 chk("cmd_idle_busy", 64'(busy_o), 64'd0);
      for (int cyc = 1; cyc <= n + 4; cyc++) begin
         @(negedge clk);
         start = glitch && (cyc == 2);
         if (glitch && cyc == 2) begin
            base_addr = AW'(16'h0100); rows = 8'd1; cols = 8'd1;
         end
         #1;
         if (cyc <= n) chk("addr", 64'(gb_addr_o), 64'(exp_addr[cyc-1]));
         chk("busy", 64'(busy_o), 64'(cyc <= n + 2));
         if (cyc < 3) begin
            chk("valid_lat", 64'(valid_o), 64'd0);
         end else if (cyc <= n + 2) begin
            chk("valid", 64'(valid_o), 64'd1);
            chk("data", 64'(data_o), 64'(word(exp_addr[cyc-3])));
            chk("last", 64'(last_o), 64'(cyc == n + 2));
         end
         chk("done", 64'(done_o), 64'(cyc == n + 3));
      end
   endtask

   initial begin
      int got, dones;
      bit prev_stall;
      logic [WW-1:0] prev_data;

      #1 check_all_zero("reset");
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;

      // 2x3 tile at full rate
      exp_addr[0] = 16'h10; exp_addr[1] = 16'h11; exp_addr[2] = 16'h12;
      exp_addr[3] = 16'h18; exp_addr[4] = 16'h19; exp_addr[5] = 16'h1A;
      run_full(16'h10, 8'd2, 8'd3, 16'd8, 6, 1'b0);

      // Same tile with ready pattern 1,0,0,1,...
      @(negedge clk);
      start = 1'b1; base_addr = 16'h10; rows = 8'd2; cols = 8'd3; stride = 16'd8;
      got = 0; dones = 0; prev_stall = 1'b0; prev_data = '0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         start = 1'b0;
         ready = (k % 3 == 0);
         #1;
         if (prev_stall) begin
            chk("stall_valid", 64'(valid_o), 64'd1);
            chk("stall_data", 64'(data_o), 64'(prev_data));
         end
         if (done_o) dones++;
         if (valid_o && ready) begin
            if (got < 6) begin
               chk("bp_data", 64'(data_o), 64'(word(exp_addr[got])));
               chk("bp_last", 64'(last_o), 64'(got == 5));
            end
            got++;
         end
         prev_stall = valid_o && !ready;
         prev_data  = data_o;
      end
      chk("bp_count", 64'(got), 64'd6);
      chk("bp_dones", 64'(dones), 64'd1);
      chk("bp_idle", 64'(busy_o), 64'd0);

      // Zero-row command: no reads, done once, address holds last value
      @(negedge clk);
      start = 1'b1; base_addr = 16'h200; rows = 8'd0; cols = 8'd5; ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      #1;
      chk("zero_done", 64'(done_o), 64'd1);
      chk("zero_busy", 64'(busy_o), 64'd0);
      chk("zero_addr", 64'(gb_addr_o), 64'h1A);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         #1;
         chk("zero_done_off", 64'(done_o), 64'd0);
         chk("zero_busy_off", 64'(busy_o), 64'd0);
         chk("zero_valid", 64'(valid_o), 64'd0);
      end

      // Address wrap-around
      exp_addr[0] = 16'hFFFE; exp_addr[1] = 16'hFFFF; exp_addr[2] = 16'h0000; exp_addr[3] = 16'h0001;
      run_full(16'hFFFE, 8'd1, 8'd4, 16'd1, 4, 1'b0);

      // Start pulsed while busy is ignored
      exp_addr[0] = 16'h10; exp_addr[1] = 16'h11; exp_addr[2] = 16'h12;
      exp_addr[3] = 16'h18; exp_addr[4] = 16'h19; exp_addr[5] = 16'h1A;
      run_full(16'h10, 8'd2, 8'd3, 16'd8, 6, 1'b1);

      // Reset after three transfers, then a fresh command
      @(negedge clk);
      start = 1'b1; base_addr = 16'h10; rows = 8'd2; cols = 8'd3; stride = 16'd8; ready = 1'b1;
      for (int cyc = 1; cyc <= 5; cyc++) begin
         @(negedge clk);
         start = 1'b0;
      end
      #1 chk("pre_rst_data", 64'(data_o), 64'(word(16'h12)));
      @(negedge clk);
      rst_n = 1'b0;
      #1 check_all_zero("midrst");
      @(negedge clk); @(negedge clk);
      #1 check_all_zero("midrst_hold");
      rst_n = 1'b1;
      exp_addr[0] = 16'h40; exp_addr[1] = 16'h41;
      run_full(16'h40, 8'd1, 8'd2, 16'd0, 2, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
